// File: rtl/dcache_pkg.sv
// Shared parameters, tag-field layout and FSM state encoding for the dcache controller.
package dcache_pkg;

  localparam int TAG_W      = 23;
  localparam int IDX_W      = 4;
  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;
  localparam int NUM_WORDS  = LINE_W / WORD_W;
  localparam int WSEL_W     = 3;
  localparam int ADDR_W     = 32;
  localparam int OFF_W      = 5;

  // SRAM tag word is {valid, dirty, tag}
  localparam int SRAM_TAG_W = TAG_W + 2;
  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_e;

  // Builds the SRAM tag word from its three fields.
  function automatic logic [SRAM_TAG_W-1:0] make_tag(input logic valid,
                                                     input logic dirty,
                                                     input logic [TAG_W-1:0] tag);
    return {valid, dirty, tag};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU, SRAM and memory signal bundle around the dcache controller.
// master = controller side, slave = CPU/SRAM/memory environment side.
interface dcache_if;
  import dcache_pkg::*;

  // CPU port
  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [WORD_W-1:0]     cpu_data_i;
  logic                  cpu_MemRead_i;
  logic                  cpu_MemWrite_i;
  logic [WORD_W-1:0]     cpu_data_o;
  logic                  cpu_stall_o;

  // Tag/data SRAM port
  logic [IDX_W-1:0]      sram_addr_o;
  logic [SRAM_TAG_W-1:0] sram_tag_o;
  logic [LINE_W-1:0]     sram_data_o;
  logic                  sram_enable_o;
  logic                  sram_write_o;
  logic                  sram_write_hit_o;
  logic [SRAM_TAG_W-1:0] sram_tag_i;
  logic [LINE_W-1:0]     sram_data_i;
  logic                  sram_hit_i;

  // Off-chip memory port
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [LINE_W-1:0]     mem_data_o;
  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [LINE_W-1:0]     mem_data_i;
  logic                  mem_ack_i;

  modport master (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o, sram_write_hit_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o, sram_write_hit_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    output mem_data_i, mem_ack_i
  );

endinterface

// File: rtl/dcache_word_merge.sv
// Combinational word extract from a cache line and word insert into a cache line.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [LINE_W-1:0] line_o,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] words [NUM_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign words[gi] = line_i[gi*WORD_W +: WORD_W];
      assign line_o[gi*WORD_W +: WORD_W] =
        (word_sel_i == WSEL_W'(gi)) ? word_i : line_i[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign word_o = words[word_sel_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: zero-wait hits, store merge, dirty write-back and line fill on miss.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.master bus
);

  // Address split
  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [WSEL_W-1:0] cpu_word;
  logic [1:0]        unused_byte_off;

  assign cpu_tag         = bus.cpu_addr_i[31:9];
  assign cpu_idx         = bus.cpu_addr_i[8:5];
  assign cpu_word        = bus.cpu_addr_i[4:2];
  assign unused_byte_off = bus.cpu_addr_i[1:0];

  // A simultaneous read and write is handled as a write
  logic req;
  logic is_write;
  assign req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign is_write = bus.cpu_MemWrite_i;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic [TAG_W-1:0]  victim_tag_q, victim_tag_d;
  logic [LINE_W-1:0] victim_data_q, victim_data_d;
  logic [LINE_W-1:0] fill_q, fill_d;

  logic [LINE_W-1:0] merged_line;
  logic [WORD_W-1:0] load_word;

  dcache_word_merge u_merge (
    .line_i     (bus.sram_data_i),
    .word_sel_i (cpu_word),
    .word_i     (bus.cpu_data_i),
    .line_o     (merged_line),
    .word_o     (load_word)
  );

  assign bus.cpu_data_o  = load_word;
  assign bus.cpu_stall_o = req & (~bus.sram_hit_i | (state_q != IDLE));

  // Once a miss is taken the latched set is used, so a dropped request still fills the right set
  assign bus.sram_addr_o   = (state_q == IDLE) ? cpu_idx : req_idx_q;
  assign bus.sram_enable_o = req | (state_q != IDLE);

  // State and miss buffers; reset drops the memory request immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      req_tag_q     <= '0;
      req_idx_q     <= '0;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      fill_q        <= '0;
    end else begin
      state_q       <= state_d;
      req_tag_q     <= req_tag_d;
      req_idx_q     <= req_idx_d;
      victim_tag_q  <= victim_tag_d;
      victim_data_q <= victim_data_d;
      fill_q        <= fill_d;
    end
  end

  logic [SRAM_TAG_W-1:0] sram_tag;
  logic [LINE_W-1:0]     sram_data;
  logic                  sram_write;
  logic                  sram_write_hit;
  logic [ADDR_W-1:0]     mem_addr;
  logic [LINE_W-1:0]     mem_data;
  logic                  mem_enable;
  logic                  mem_write;

  // Next-state, buffer capture and SRAM/memory strobes
  always_comb begin
    state_d        = state_q;
    req_tag_d      = req_tag_q;
    req_idx_d      = req_idx_q;
    victim_tag_d   = victim_tag_q;
    victim_data_d  = victim_data_q;
    fill_d         = fill_q;
    sram_tag       = make_tag(1'b0, 1'b0, cpu_tag);
    sram_data      = merged_line;
    sram_write     = 1'b0;
    sram_write_hit = 1'b0;
    mem_addr       = '0;
    mem_data       = '0;
    mem_enable     = 1'b0;
    mem_write      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (bus.sram_hit_i) begin
            if (is_write) begin
              sram_write     = 1'b1;
              sram_write_hit = 1'b1;
              sram_tag       = make_tag(1'b1, 1'b1, cpu_tag);
              sram_data      = merged_line;
            end
          end else begin
            req_tag_d = cpu_tag;
            req_idx_d = cpu_idx;
            state_d   = MISS;
          end
        end
      end

      MISS: begin
        if (bus.sram_tag_i[VALID_BIT] & bus.sram_tag_i[DIRTY_BIT]) begin
          victim_tag_d  = bus.sram_tag_i[TAG_W-1:0];
          victim_data_d = bus.sram_data_i;
          state_d       = WRITEBACK;
        end else begin
          state_d = READMISS;
        end
      end

      WRITEBACK: begin
        mem_enable = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {victim_tag_q, req_idx_q, {OFF_W{1'b0}}};
        mem_data   = victim_data_q;
        if (bus.mem_ack_i) begin
          state_d = READMISS;
        end
      end

      READMISS: begin
        mem_enable = 1'b1;
        mem_addr   = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
        if (bus.mem_ack_i) begin
          fill_d  = bus.mem_data_i;
          state_d = READMISSOK;
        end
      end

      READMISSOK: begin
        sram_write = 1'b1;
        sram_tag   = make_tag(1'b1, 1'b0, req_tag_q);
        sram_data  = fill_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.sram_tag_o       = sram_tag;
  assign bus.sram_data_o      = sram_data;
  assign bus.sram_write_o     = sram_write;
  assign bus.sram_write_hit_o = sram_write_hit;
  assign bus.mem_addr_o       = mem_addr;
  assign bus.mem_data_o       = mem_data;
  assign bus.mem_enable_o     = mem_enable;
  assign bus.mem_write_o      = mem_write;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: bench drives the SRAM and memory responses cycle by cycle.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk_i;
  logic rst_i;
  int   n_checks;
  int   n_errors;

  dcache_if bus_if ();

  dcache_ctrl u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] put_word(input logic [255:0] line, input int w,
                                            input logic [31:0] v);
    logic [255:0] l;
    l = line;
    l[w*32 +: 32] = v;
    return l;
  endfunction

  // Advance to the next falling edge, passing one rising edge
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic bus_idle();
    bus_if.cpu_addr_i     = '0;
    bus_if.cpu_data_i     = '0;
    bus_if.cpu_MemRead_i  = 1'b0;
    bus_if.cpu_MemWrite_i = 1'b0;
    bus_if.sram_tag_i     = '0;
    bus_if.sram_data_i    = '0;
    bus_if.sram_hit_i     = 1'b0;
    bus_if.mem_data_i     = '0;
    bus_if.mem_ack_i      = 1'b0;
  endtask

  logic [255:0] line_a, fill_b, victim_c, fill_c, exp_line;

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus_idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("rst_mem_en",   256'(bus_if.mem_enable_o), 256'(0));
    check("rst_mem_wr",   256'(bus_if.mem_write_o),  256'(0));
    check("rst_mem_addr", 256'(bus_if.mem_addr_o),   256'(0));
    check("rst_mem_data", bus_if.mem_data_o,          256'(0));
    check("rst_stall",    256'(bus_if.cpu_stall_o),  256'(0));
    tick();
    rst_i = 1'b0;
    tick();

    // 1. Read hit at 0x44 (idx 2, word 1)
    line_a = put_word(256'(0), 1, 32'hDEADBEEF);
    bus_if.cpu_addr_i    = 32'h0000_0044;
    bus_if.cpu_MemRead_i = 1'b1;
    bus_if.sram_hit_i    = 1'b1;
    bus_if.sram_tag_i    = 25'h100_0000;
    bus_if.sram_data_i   = line_a;
    #1;
    check("t1_data",   256'(bus_if.cpu_data_o),   256'(32'hDEADBEEF));
    check("t1_stall",  256'(bus_if.cpu_stall_o),  256'(0));
    check("t1_mem_en", 256'(bus_if.mem_enable_o), 256'(0));
    check("t1_swr",    256'(bus_if.sram_write_o), 256'(0));
    check("t1_sidx",   256'(bus_if.sram_addr_o),  256'(2));
    check("t1_sen",    256'(bus_if.sram_enable_o), 256'(1));
    $display("txn 1 read hit 0x44 data=%08h", bus_if.cpu_data_o);
    tick();
    bus_idle();
    tick();

    // 2. Read miss at 0x44, clean victim, ack on the third memory cycle
    fill_b = put_word(256'(0), 1, 32'h12345678);
    bus_if.cpu_addr_i    = 32'h0000_0044;
    bus_if.cpu_MemRead_i = 1'b1;
    bus_if.sram_tag_i    = 25'h100_0009;
    bus_if.sram_data_i   = line_a;
    #1;
    check("t2_stall0", 256'(bus_if.cpu_stall_o),  256'(1));
    check("t2_men0",   256'(bus_if.mem_enable_o), 256'(0));
    tick();                                   // MISS
    #1;
    check("t2_men_miss", 256'(bus_if.mem_enable_o), 256'(0));
    tick();                                   // READMISS cycle 1
    #1;
    check("t2_men",   256'(bus_if.mem_enable_o), 256'(1));
    check("t2_mwr",   256'(bus_if.mem_write_o),  256'(0));
    check("t2_maddr", 256'(bus_if.mem_addr_o),   256'(32'h0000_0040));
    tick();                                   // cycle 2
    tick();                                   // cycle 3: ack
    #1;
    check("t2_men_hold", 256'(bus_if.mem_enable_o), 256'(1));
    bus_if.mem_ack_i  = 1'b1;
    bus_if.mem_data_i = fill_b;
    tick();                                   // READMISSOK
    bus_if.mem_ack_i  = 1'b0;
    bus_if.mem_data_i = '0;
    #1;
    check("t2_men_drop", 256'(bus_if.mem_enable_o),     256'(0));
    check("t2_swr",      256'(bus_if.sram_write_o),     256'(1));
    check("t2_swh",      256'(bus_if.sram_write_hit_o), 256'(0));
    check("t2_stag",     256'(bus_if.sram_tag_o),       256'(25'h100_0000));
    check("t2_sdata",    bus_if.sram_data_o,             fill_b);
    check("t2_stall_ok", 256'(bus_if.cpu_stall_o),      256'(1));
    tick();                                   // IDLE, now a hit
    bus_if.sram_hit_i  = 1'b1;
    bus_if.sram_tag_i  = 25'h100_0000;
    bus_if.sram_data_i = fill_b;
    #1;
    check("t2_stall_end", 256'(bus_if.cpu_stall_o), 256'(0));
    check("t2_data",      256'(bus_if.cpu_data_o),  256'(32'h12345678));
    $display("txn 2 read miss 0x44 data=%08h", bus_if.cpu_data_o);
    tick();
    bus_idle();
    tick();

    // 3. Write miss at 0x44C (tag 2, idx 2, word 3), dirty victim tag 1
    victim_c = put_word(256'(0), 5, 32'hBADC0DE5);
    fill_c   = put_word(256'(0), 0, 32'h0BADF00D);
    bus_if.cpu_addr_i     = 32'h0000_044C;
    bus_if.cpu_data_i     = 32'hCAFEF00D;
    bus_if.cpu_MemWrite_i = 1'b1;
    bus_if.sram_tag_i     = 25'h180_0001;
    bus_if.sram_data_i    = victim_c;
    #1;
    check("t3_stall0", 256'(bus_if.cpu_stall_o),  256'(1));
    check("t3_swr0",   256'(bus_if.sram_write_o), 256'(0));
    tick();                                   // MISS
    tick();                                   // WRITEBACK
    bus_if.sram_tag_i  = '0;
    bus_if.sram_data_i = '0;
    #1;
    check("t3_wb_en",   256'(bus_if.mem_enable_o), 256'(1));
    check("t3_wb_wr",   256'(bus_if.mem_write_o),  256'(1));
    check("t3_wb_addr", 256'(bus_if.mem_addr_o),   256'(32'h0000_0240));
    check("t3_wb_data", bus_if.mem_data_o,          victim_c);
    tick();
    bus_if.mem_ack_i = 1'b1;
    tick();                                   // READMISS
    bus_if.mem_ack_i = 1'b0;
    #1;
    check("t3_rm_en",   256'(bus_if.mem_enable_o), 256'(1));
    check("t3_rm_wr",   256'(bus_if.mem_write_o),  256'(0));
    check("t3_rm_addr", 256'(bus_if.mem_addr_o),   256'(32'h0000_0440));
    bus_if.mem_ack_i  = 1'b1;
    bus_if.mem_data_i = fill_c;
    tick();                                   // READMISSOK
    bus_if.mem_ack_i  = 1'b0;
    bus_if.mem_data_i = '0;
    #1;
    check("t3_fill_tag",  256'(bus_if.sram_tag_o), 256'(25'h100_0002));
    check("t3_fill_data", bus_if.sram_data_o,       fill_c);
    tick();                                   // IDLE, write hit
    bus_if.sram_hit_i  = 1'b1;
    bus_if.sram_tag_i  = 25'h100_0002;
    bus_if.sram_data_i = fill_c;
    exp_line = put_word(fill_c, 3, 32'hCAFEF00D);
    #1;
    check("t3_hit_wr",  256'(bus_if.sram_write_o),     256'(1));
    check("t3_hit_wh",  256'(bus_if.sram_write_hit_o), 256'(1));
    check("t3_hit_tag", 256'(bus_if.sram_tag_o),       256'(25'h180_0002));
    check("t3_hit_dat", bus_if.sram_data_o,             exp_line);
    check("t3_stall",   256'(bus_if.cpu_stall_o),      256'(0));
    $display("txn 3 write miss 0x44C wb=0x240 tag=%07h", bus_if.sram_tag_o);
    tick();
    bus_idle();
    tick();

    // 4. Write hit at 0x6BC (tag 3, idx 5, word 7)
    line_a = {8{32'h01020304}};
    exp_line = {32'hA5A5A5A5, line_a[223:0]};
    bus_if.cpu_addr_i     = 32'h0000_06BC;
    bus_if.cpu_data_i     = 32'hA5A5A5A5;
    bus_if.cpu_MemWrite_i = 1'b1;
    bus_if.sram_hit_i     = 1'b1;
    bus_if.sram_tag_i     = 25'h100_0003;
    bus_if.sram_data_i    = line_a;
    #1;
    check("t4_wh",    256'(bus_if.sram_write_hit_o), 256'(1));
    check("t4_wr",    256'(bus_if.sram_write_o),     256'(1));
    check("t4_data",  bus_if.sram_data_o,             exp_line);
    check("t4_tag",   256'(bus_if.sram_tag_o),       256'(25'h180_0003));
    check("t4_sidx",  256'(bus_if.sram_addr_o),      256'(5));
    check("t4_stall", 256'(bus_if.cpu_stall_o),      256'(0));
    $display("txn 4 write hit 0x6BC word7 line=%0h", bus_if.sram_data_o);
    tick();
    bus_idle();
    tick();

    // 5. Read miss at 0x6A0 with ack in the first READMISS cycle
    fill_b = put_word(256'(0), 0, 32'h55AA33CC);
    bus_if.cpu_addr_i    = 32'h0000_06A0;
    bus_if.cpu_MemRead_i = 1'b1;
    tick();                                   // MISS
    tick();                                   // READMISS
    #1;
    check("t5_men",   256'(bus_if.mem_enable_o), 256'(1));
    check("t5_maddr", 256'(bus_if.mem_addr_o),   256'(32'h0000_06A0));
    bus_if.mem_ack_i  = 1'b1;
    bus_if.mem_data_i = fill_b;
    tick();                                   // READMISSOK
    bus_if.mem_ack_i  = 1'b0;
    #1;
    check("t5_no_dup", 256'(bus_if.mem_enable_o), 256'(0));
    check("t5_swr",    256'(bus_if.sram_write_o), 256'(1));
    check("t5_sdata",  bus_if.sram_data_o,         fill_b);
    tick();                                   // IDLE
    bus_if.sram_hit_i  = 1'b1;
    bus_if.sram_data_i = fill_b;
    #1;
    check("t5_men_idle", 256'(bus_if.mem_enable_o), 256'(0));
    check("t5_stall",    256'(bus_if.cpu_stall_o),  256'(0));
    check("t5_data",     256'(bus_if.cpu_data_o),   256'(32'h55AA33CC));
    $display("txn 5 fast-ack miss 0x6A0 data=%08h", bus_if.cpu_data_o);
    tick();
    bus_idle();
    tick();

    // 6. Reset during WRITEBACK, then the held request re-misses cleanly
    bus_if.cpu_addr_i     = 32'h0000_044C;
    bus_if.cpu_data_i     = 32'h11223344;
    bus_if.cpu_MemWrite_i = 1'b1;
    bus_if.sram_tag_i     = 25'h180_0001;
    bus_if.sram_data_i    = victim_c;
    tick();                                   // MISS
    tick();                                   // WRITEBACK
    #1;
    check("t6_wb_en", 256'(bus_if.mem_enable_o), 256'(1));
    #1;
    rst_i = 1'b1;
    #1;
    check("t6_rst_en",   256'(bus_if.mem_enable_o), 256'(0));
    check("t6_rst_wr",   256'(bus_if.mem_write_o),  256'(0));
    check("t6_rst_addr", 256'(bus_if.mem_addr_o),   256'(0));
    tick();
    rst_i = 1'b0;
    bus_if.sram_tag_i  = 25'h000_0000;
    bus_if.sram_data_i = '0;
    #1;
    check("t6_idle_en", 256'(bus_if.mem_enable_o), 256'(0));
    tick();                                   // MISS
    tick();                                   // READMISS (clean victim now)
    #1;
    check("t6_rm_en",   256'(bus_if.mem_enable_o), 256'(1));
    check("t6_rm_wr",   256'(bus_if.mem_write_o),  256'(0));
    check("t6_rm_addr", 256'(bus_if.mem_addr_o),   256'(32'h0000_0440));
    bus_if.mem_ack_i  = 1'b1;
    bus_if.mem_data_i = fill_c;
    tick();                                   // READMISSOK
    bus_if.mem_ack_i  = 1'b0;
    #1;
    check("t6_fill_tag", 256'(bus_if.sram_tag_o), 256'(25'h100_0002));
    tick();                                   // IDLE, write hit
    bus_if.sram_hit_i  = 1'b1;
    bus_if.sram_tag_i  = 25'h100_0002;
    bus_if.sram_data_i = fill_c;
    #1;
    check("t6_stall", 256'(bus_if.cpu_stall_o), 256'(0));
    check("t6_data",  bus_if.sram_data_o,        put_word(fill_c, 3, 32'h11223344));
    $display("txn 6 reset in writeback, re-miss tag=%07h", bus_if.sram_tag_o);
    tick();
    bus_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
